// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: funct3 codes, FSM states,
// access sizes and the small decode helpers used by the datapath.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int unsigned SZ_B_W = 8;
  localparam int unsigned SZ_H_W = 16;
  localparam int unsigned SZ_W_W = 32;
  localparam int unsigned SZ_D_W = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  func3;
    logic [2:0]  off;
    logic [63:0] wdata;
  } req_t;

  // Byte-lane mask of an access of the given size, before shifting by offset.
  function automatic logic [7:0] size_mask(input size_e sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [2:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment: extracts and extends load data from a doubleword and
// merges store bytes into a doubleword for read-modify-write.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [63:0] rdw_i,
  input  logic [63:0] wdata_i,
  input  logic [2:0]  off_i,
  input  logic [2:0]  func3_i,
  output logic [63:0] load_o,
  output logic [63:0] merge_o
);

  logic [63:0] shifted;
  logic [63:0] wshift;
  logic [7:0]  be;

  always_comb begin
    shifted = rdw_i >> {off_i, 3'b000};
    load_o  = '0;
    case (func3_i)
      F3_B:    load_o = 64'($signed(shifted[SZ_B_W-1:0]));
      F3_H:    load_o = 64'($signed(shifted[SZ_H_W-1:0]));
      F3_W:    load_o = 64'($signed(shifted[SZ_W_W-1:0]));
      F3_D:    load_o = shifted[SZ_D_W-1:0];
      F3_BU:   load_o = {{(64-SZ_B_W){1'b0}}, shifted[SZ_B_W-1:0]};
      F3_HU:   load_o = {{(64-SZ_H_W){1'b0}}, shifted[SZ_H_W-1:0]};
      F3_WU:   load_o = {{(64-SZ_W_W){1'b0}}, shifted[SZ_W_W-1:0]};
      default: load_o = '0;
    endcase
  end

  // Store data arrives right-aligned; move it to the addressed lanes and keep
  // every other byte of the old doubleword.
  always_comb begin
    wshift  = wdata_i << {off_i, 3'b000};
    be      = size_mask(size_e'(func3_i[1:0])) << off_i;
    merge_o = rdw_i;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) merge_o[8*b +: 8] = wshift[8*b +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data-memory responder for an RV64 core: one request at a time,
// sub-doubleword stores via read-modify-write, errors answered without side effects.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_DW  = 512,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_DW > 1) ? $clog2(DEPTH_DW) : 1;

  logic [1:0]       state_q, state_d;
  logic [63:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  req_t             req_q;
  logic [IDX_W-1:0] idx_q;
  logic [63:0]      rdw_q;

  logic             accept;
  logic             req_err;
  logic             mem_re, mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [63:0]      load_data, merge_data;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    if (!req_we && req_func3 == 3'b111) req_err = 1'b1;
    if (req_we && req_func3[2]) req_err = 1'b1;
    if (misaligned(size_e'(req_func3[1:0]), req_addr[2:0])) req_err = 1'b1;
    if (req_addr[63:3] >= 61'(DEPTH_DW)) req_err = 1'b1;
  end

  // The single array port reads at acceptance and writes only in WRITE.
  assign mem_idx = (state_q == ST_IDLE) ? req_addr[IDX_W+2:3] : idx_q;
  assign mem_re  = accept && !req_err;
  assign mem_we  = (state_q == ST_WRITE);

  generate
    if (INIT_ZERO) begin : g_mem_zero
      logic [63:0] mem [DEPTH_DW] = '{default: 64'h0};
      always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= merge_data;
        if (mem_re) rdw_q <= mem[mem_idx];
      end
    end else begin : g_mem
      logic [63:0] mem [DEPTH_DW];
      always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= merge_data;
        if (mem_re) rdw_q <= mem[mem_idx];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (accept) begin
      req_q.we    <= req_we;
      req_q.func3 <= req_func3;
      req_q.off   <= req_addr[2:0];
      req_q.wdata <= req_wdata;
      idx_q       <= req_addr[IDX_W+2:3];
    end
  end

  dmem_lane_align u_align (
    .rdw_i   (rdw_q),
    .wdata_i (req_q.wdata),
    .off_i   (req_q.off),
    .func3_i (req_q.func3),
    .load_o  (load_data),
    .merge_o (merge_data)
  );

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_d     = ST_RESP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else if (req_we && req_func3[1:0] == SZ_D) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (req_q.we) begin
          state_d = ST_WRITE;
        end else begin
          state_d     = ST_RESP;
          rsp_rdata_d = load_data;
          rsp_err_d   = 1'b0;
        end
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a byte-addressed memory model
// whose transactions commit when their response is handshaken.
module tb_dmem_responder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [2:0]  req_func3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH_DW(DEPTH), .INIT_ZERO(1'b0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_func3 (req_func3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          due;
    int          acc;
    logic        wr;
    logic [63:0] addr;
    int          nb;
    logic [63:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mb [DEPTH*8];
  logic [63:0] init_dw [DEPTH];

  int          n_checks = 0;
  int          n_err = 0;
  int          stall_left = -1;
  logic        pop_pending = 1'b0;
  logic        first_seen = 1'b0;
  int          obs_lat = 0;
  int          vcyc = 0;
  logic [63:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          last_lat = 0;
  int          last_vcyc = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nbytes(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic is_err(logic we, logic [63:0] a, logic [2:0] f3);
    if (!we && f3 == 3'b111) return 1'b1;
    if (we && f3[2]) return 1'b1;
    if ((a % 64'(nbytes(f3))) != 0) return 1'b1;
    if ((a >> 3) >= 64'(DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] load_val(logic [63:0] a, logic [2:0] f3);
    logic [63:0] v;
    int n;
    n = nbytes(f3);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mb[int'(a) + i];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic void commit(exp_t e);
    if (e.wr && !e.err)
      for (int i = 0; i < e.nb; i++) mb[int'(e.addr) + i] = e.wdata[8*i +: 8];
  endfunction

  // ---------------- compare process ----------------
  initial begin : monitor
    exp_t e;
    logic busy, expv;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset rsp_rdata", rsp_rdata, 64'd0);
        chk("reset rsp_err", 64'(rsp_err), 64'd0);
        exp_q.delete();
        pop_pending = 1'b0;
        first_seen  = 1'b0;
        vcyc        = 0;
        stall_left  = -1;
        rsp_ready   = 1'($urandom % 2);
      end else begin
        if (pop_pending) begin
          commit(exp_q[0]);
          last_lat  = first_seen ? obs_lat : -1;
          last_vcyc = vcyc;
          void'(exp_q.pop_front());
          pop_pending = 1'b0;
          first_seen  = 1'b0;
          vcyc        = 0;
        end
        busy = (exp_q.size() != 0);
        expv = 1'b0;
        if (busy) begin
          e    = exp_q[0];
          expv = (cyc >= e.due);
        end
        chk("req_ready", 64'(req_ready), 64'(!busy));
        chk("rsp_valid", 64'(rsp_valid), 64'(expv));
        if (busy && rsp_valid && !first_seen) begin
          first_seen = 1'b1;
          obs_lat    = cyc - e.acc + 1;
        end
        if (expv) begin
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
          vcyc++;
          if (stall_left > 0) begin
            rsp_ready = 1'b0;
            stall_left--;
          end else if (stall_left == 0) begin
            rsp_ready  = 1'b1;
            stall_left = -1;
          end else begin
            rsp_ready = 1'($urandom % 2);
          end
          pop_pending = rsp_ready;
        end else begin
          rsp_ready = 1'($urandom % 2);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 || !reset_n) break;
      req_valid = 1'($urandom % 2);
      req_we    = 1'($urandom % 2);
      req_addr  = 64'($urandom % 256);
      req_wdata = {$urandom, $urandom};
      req_func3 = 3'($urandom % 8);
      t++;
      if (t > 200) begin
        n_checks++;
        n_err++;
        $display("FAIL response timeout: got no handshake expected one within 200 cycles");
        finish_sim();
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic issue(logic we, logic [63:0] a, logic [63:0] wd, logic [2:0] f3);
    exp_t e;
    int   lat;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_func3 = f3;
    @(posedge clk);
    #1;
    e.err   = is_err(we, a, f3);
    e.rdata = (e.err || we) ? 64'd0 : load_val(a, f3);
    if (e.err) lat = 1;
    else if (!we || f3[1:0] == 2'b11) lat = 2;
    else lat = 3;
    e.acc   = cyc;
    e.due   = cyc + lat - 1;
    e.wr    = we;
    e.addr  = a;
    e.nb    = nbytes(f3);
    e.wdata = wd;
    exp_q.push_back(e);
  endtask

  task automatic txn(logic we, logic [63:0] a, logic [63:0] wd, logic [2:0] f3);
    wait_idle();
    issue(we, a, wd, f3);
    wait_idle();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic        we;
    logic [2:0]  f3;
    logic [63:0] a;
    for (int i = 0; i < DEPTH * 8; i++) mb[i] = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      init_dw[i] = {$urandom, $urandom};
      txn(1'b1, 64'(i * 8), init_dw[i], 3'b011);
    end

    txn(1'b1, 64'h10, 64'h8877665544332211, 3'b011);
    chk("SD latency", 64'(last_lat), 64'd2);
    chk("SD err", 64'(last_err), 64'd0);
    txn(1'b0, 64'h10, 64'h0, 3'b011);
    chk("LD data", last_rdata, 64'h8877665544332211);
    chk("LD err", 64'(last_err), 64'd0);
    chk("LD latency", 64'(last_lat), 64'd2);
    txn(1'b0, 64'h17, 64'h0, 3'b000);
    chk("LB data", last_rdata, 64'hFFFFFFFFFFFFFF88);
    txn(1'b0, 64'h17, 64'h0, 3'b100);
    chk("LBU data", last_rdata, 64'h0000000000000088);
    txn(1'b0, 64'h14, 64'h0, 3'b010);
    chk("LW data", last_rdata, 64'hFFFFFFFF88776655);

    txn(1'b1, 64'h12, 64'hDEADBEEFCAFE00AB, 3'b000);
    chk("SB latency", 64'(last_lat), 64'd3);
    chk("SB rdata", last_rdata, 64'd0);
    txn(1'b0, 64'h10, 64'h0, 3'b011);
    chk("LD after SB", last_rdata, 64'h8877665544AB2211);

    txn(1'b0, 64'h11, 64'h0, 3'b001);
    chk("LH misaligned err", 64'(last_err), 64'd1);
    chk("LH misaligned rdata", last_rdata, 64'd0);
    chk("error latency", 64'(last_lat), 64'd1);
    txn(1'b1, 64'h10, 64'h55, 3'b100);
    chk("store f3=100 err", 64'(last_err), 64'd1);
    txn(1'b1, 64'(8 * DEPTH), 64'hFFFFFFFFFFFFFFFF, 3'b011);
    chk("SD out of range err", 64'(last_err), 64'd1);
    txn(1'b0, 64'h0, 64'h0, 3'b011);
    chk("dw0 unchanged", last_rdata, init_dw[0]);
    txn(1'b0, 64'(8 * DEPTH - 8), 64'h0, 3'b011);
    chk("last dw unchanged", last_rdata, init_dw[DEPTH-1]);

    stall_left = 5;
    txn(1'b0, 64'h10, 64'h0, 3'b011);
    chk("stalled response cycles", 64'(last_vcyc), 64'd6);
    chk("stalled LD data", last_rdata, 64'h8877665544AB2211);

    wait_idle();
    issue(1'b1, 64'h10, 64'h0000000012345678, 3'b010);
    #2;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    txn(1'b0, 64'h10, 64'h0, 3'b011);
    chk("dw after aborted SW", last_rdata, 64'h8877665544AB2211);

    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      if ($urandom % 16 == 0) a = ($urandom % 2) ? {$urandom, $urandom} : 64'(8 * DEPTH + $urandom % 64);
      else a = 64'($urandom % (8 * DEPTH));
      if ($urandom % 4 != 0) a = a & ~64'(nbytes(f3) - 1);
      txn(we, a, {$urandom, $urandom}, f3);
      if ($urandom % 4 == 0) begin
        @(negedge clk);
        #2;
      end
    end

    finish_sim();
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_DW, default 512, meaning the number of 64-bit doublewords stored.
REQ-002 SHALL have parameter INIT_ZERO, default 0; when 1, simulation storage is zero-filled at time 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the core presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 for a store, 0 for a load.
REQ-008 SHALL have port req_addr, input, 64 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 64 bits: store data, right-aligned.
REQ-010 SHALL have port req_func3, input, 3 bits: RV64 load/store funct3 size and sign code.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a response is pending.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the core accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 64 bits: load data, extended per func3; 0 for stores.
REQ-014 SHALL have port rsp_err, output, 1 bit: the request was rejected without any side effect.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid && req_ready at a rising edge, and all req_* fields are captured on that edge.
REQ-017 SHALL decode func3 as follows: loads 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; stores 000 SB, 001 SH, 010 SW, 011 SD.
REQ-018 SHALL flag an error on acceptance for any of: load func3=111; store func3[2]=1; misalignment (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0); or addr[63:3] >= DEPTH_DW.
REQ-019 SHALL handle an error request as IDLE -> RESP directly, with rsp_err=1, rsp_rdata=0, and no storage write.
REQ-020 SHALL handle a valid load as IDLE -> READ -> RESP: synchronous array read in READ, and rsp_valid asserted 2 cycles after acceptance.
REQ-021 SHALL extract the load lane using addr[2:0], then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU); LD returns the full doubleword.
REQ-022 SHALL handle SD as IDLE -> WRITE -> RESP, writing the full doubleword in WRITE; rsp_valid 2 cycles after acceptance.
REQ-023 SHALL handle SB/SH/SW as IDLE -> READ -> WRITE -> RESP: read-modify-write, merging only the addressed bytes from req_wdata low bits; rsp_valid 3 cycles after acceptance.
REQ-024 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-025 SHALL not accept a new request in the RESP-to-IDLE cycle, because req_ready is 0 in RESP; the next acceptance occurs no earlier than the following cycle.
REQ-026 SHALL drive rsp_valid=0 and leave rsp_rdata/rsp_err unspecified-stable (last value) outside RESP.
REQ-027 SHALL give a store immediately followed by a load to the same doubleword the newly written data (no bypass is needed because the accesses are serialized).
REQ-028 SHALL ignore req_* when req_ready=0.

Reset
REQ-029 SHALL, while reset_n=0, force state=IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-030 SHALL, on reset asserted mid-operation, abort the operation; a store not yet in WRITE leaves storage unmodified, and no response is produced for the aborted request.
REQ-031 SHALL not reset storage contents.

Structure
REQ-032 SHALL place the func3 encodings, the FSM state encoding, and the access-size widths in shared package dmem_pkg.
REQ-033 SHALL implement lane extraction/extension and store-byte merging in one combinational sub-module, dmem_lane_align.
REQ-034 SHALL infer storage as a single-port synchronous-read array of DEPTH_DW x 64.

Verification
REQ-035 SHALL cover: SD addr 0x10 data 0x8877665544332211, then LD 0x10 -> rsp_rdata 0x8877665544332211, rsp_err=0, SD response 2 cycles after acceptance.
REQ-036 SHALL cover: after REQ-035, LB 0x17 -> 0xFFFFFFFFFFFFFF88; LBU 0x17 -> 0x0000000000000088; LW 0x14 -> 0xFFFFFFFF88776655.
REQ-037 SHALL cover: SB 0x12 data 0xAB, then LD 0x10 -> 0x8877665544AB2211, SB response 3 cycles after acceptance.
REQ-038 SHALL cover: LH 0x11 -> rsp_err=1, rsp_rdata=0; store func3=100 -> rsp_err=1; SD addr 8*DEPTH_DW -> rsp_err=1 with storage unchanged.
REQ-039 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout.
REQ-040 SHALL cover: SW accepted, reset_n pulsed low in the READ cycle -> rsp_valid=0 and the target doubleword unchanged on re-read.
